// File: rtl/instr_realign_buf_if.sv
// Fetch-word and aligned-instruction handshakes of the instruction realigner.
// The slave modport is the realigner; the master modport drives fetch words and consumes instructions.
interface instr_realign_buf_if #(
    parameter int ADDR_W = 64
);
    logic              fetch_valid_i;
    logic              fetch_ready_o;
    logic [ADDR_W-1:0] fetch_addr_i;
    logic [31:0]       fetch_data_i;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_addr_o;
    logic              is_compressed_o;

    modport slave (
        input  fetch_valid_i,
        input  fetch_addr_i,
        input  fetch_data_i,
        input  instr_ready_i,
        output fetch_ready_o,
        output instr_valid_o,
        output instr_o,
        output instr_addr_o,
        output is_compressed_o
    );

    modport master (
        output fetch_valid_i,
        output fetch_addr_i,
        output fetch_data_i,
        output instr_ready_i,
        input  fetch_ready_o,
        input  instr_valid_o,
        input  instr_o,
        input  instr_addr_o,
        input  is_compressed_o
    );
endinterface

// File: rtl/instr_realign_buf.sv
// Realigns halfword-aligned RVC/32-bit instructions from 32-bit fetch words, one per cycle.
// Optional macro REALIGN_STRADDLE_FLAG_EN adds straddle_o (32-bit head split across two fetch words).
module instr_realign_buf #(
    parameter int ADDR_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
`ifdef REALIGN_STRADDLE_FLAG_EN
    output logic                straddle_o,
`endif
    instr_realign_buf_if.slave  bus
);

    logic [15:0]       hw_q [3];
    logic [15:0]       hw_d [3];
    logic [15:0]       sh   [3];
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic [1:0]        cnt_ap;
    logic [ADDR_W-1:0] head_q;
    logic [ADDR_W-1:0] head_d;
    logic [ADDR_W-1:0] head_ap;

    logic rvc;
    logic head_valid;
    logic fetch_ready;
    logic pop;
    logic push;

    assign rvc         = (hw_q[0][1:0] != 2'b11);
    assign head_valid  = ((cnt_q != 2'd0) && rvc) || (cnt_q >= 2'd2);
    assign fetch_ready = (cnt_q <= 2'd1);
    // Flush suppresses both handshakes so a redirect never mixes with stale state.
    assign pop         = head_valid && bus.instr_ready_i && !flush_i;
    assign push        = bus.fetch_valid_i && fetch_ready && !flush_i;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sh[i] = hw_q[i];
        end
        cnt_ap  = cnt_q;
        head_ap = head_q;
        if (pop) begin
            if (rvc) begin
                sh[0]   = hw_q[1];
                sh[1]   = hw_q[2];
                cnt_ap  = cnt_q - 2'd1;
                head_ap = head_q + ADDR_W'(2);
            end else begin
                sh[0]   = hw_q[2];
                cnt_ap  = cnt_q - 2'd2;
                head_ap = head_q + ADDR_W'(4);
            end
        end

        hw_d   = sh;
        cnt_d  = cnt_ap;
        head_d = head_ap;
        // Push lands behind whatever survived the pop; at most one halfword survives.
        if (push) begin
            if (cnt_ap == 2'd0) begin
                head_d = {bus.fetch_addr_i[ADDR_W-1:1], 1'b0};
                if (bus.fetch_addr_i[1]) begin
                    hw_d[0] = bus.fetch_data_i[31:16];
                    cnt_d   = 2'd1;
                end else begin
                    hw_d[0] = bus.fetch_data_i[15:0];
                    hw_d[1] = bus.fetch_data_i[31:16];
                    cnt_d   = 2'd2;
                end
            end else begin
                hw_d[1] = bus.fetch_data_i[15:0];
                hw_d[2] = bus.fetch_data_i[31:16];
                cnt_d   = 2'd3;
            end
        end
        if (flush_i) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
        hw_q   <= hw_d;
        head_q <= head_d;
    end

    assign bus.fetch_ready_o   = fetch_ready;
    assign bus.instr_valid_o   = head_valid;
    assign bus.is_compressed_o = head_valid && rvc;
    assign bus.instr_addr_o    = head_valid ? head_q : '0;
    assign bus.instr_o         = !head_valid ? 32'h0 :
                                 rvc         ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};

`ifdef REALIGN_STRADDLE_FLAG_EN
    // Each accepted word flips wtag_q, so halves of one instruction differ in tag only when split.
    logic tag_q [3];
    logic tag_d [3];
    logic wtag_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tag_d[i] = tag_q[i];
        end
        if (pop) begin
            if (rvc) begin
                tag_d[0] = tag_q[1];
                tag_d[1] = tag_q[2];
            end else begin
                tag_d[0] = tag_q[2];
            end
        end
        if (push) begin
            if (cnt_ap == 2'd0) begin
                tag_d[0] = wtag_q;
                tag_d[1] = wtag_q;
            end else begin
                tag_d[1] = wtag_q;
                tag_d[2] = wtag_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wtag_q <= 1'b0;
        end else if (push) begin
            wtag_q <= ~wtag_q;
        end
        tag_q <= tag_d;
    end

    assign straddle_o = head_valid && !rvc && (tag_q[0] != tag_q[1]);
`endif

endmodule

// File: tb/tb_instr_realign_buf.sv
// Bench for instr_realign_buf: halfword-queue reference model checked every cycle, plus directed literals.
module tb_instr_realign_buf;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    instr_realign_buf_if #(.ADDR_W(64)) bus ();

`ifdef REALIGN_STRADDLE_FLAG_EN
    logic straddle;
`endif

    instr_realign_buf #(.ADDR_W(64)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
`ifdef REALIGN_STRADDLE_FLAG_EN
        .straddle_o (straddle),
`endif
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: a queue of halfwords, each with its own PC and the id of the word it came from.
    typedef struct {
        logic [15:0] h;
        logic [63:0] pc;
        int          wid;
    } hw_t;
    hw_t mq[$];
    int  wid_ctr = 0;

    function automatic bit m_valid();
        if (mq.size() >= 2) return 1'b1;
        if (mq.size() == 1) return (mq[0].h[1:0] != 2'b11);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit          rdy_before;
        logic [63:0] base;
        hw_t         e;
        if (rst || flush) begin
            mq.delete();
        end else begin
            rdy_before = (mq.size() <= 1);
            if (m_valid() && bus.instr_ready_i) begin
                if (mq[0].h[1:0] != 2'b11) void'(mq.pop_front());
                else begin void'(mq.pop_front()); void'(mq.pop_front()); end
            end
            if (bus.fetch_valid_i && rdy_before) begin
                if (mq.size() == 0) begin
                    base = {bus.fetch_addr_i[63:1], 1'b0};
                    if (bus.fetch_addr_i[1]) begin
                        e.h = bus.fetch_data_i[31:16]; e.pc = base; e.wid = wid_ctr; mq.push_back(e);
                    end else begin
                        e.h = bus.fetch_data_i[15:0];  e.pc = base;     e.wid = wid_ctr; mq.push_back(e);
                        e.h = bus.fetch_data_i[31:16]; e.pc = base + 2; e.wid = wid_ctr; mq.push_back(e);
                    end
                end else begin
                    base = mq[mq.size()-1].pc;
                    e.h = bus.fetch_data_i[15:0];  e.pc = base + 2; e.wid = wid_ctr; mq.push_back(e);
                    e.h = bus.fetch_data_i[31:16]; e.pc = base + 4; e.wid = wid_ctr; mq.push_back(e);
                end
                wid_ctr++;
            end
        end
    end

    always @(negedge clk) begin
        bit          v;
        bit          c;
        logic [31:0] ei;
        if (cmp_en) begin
            v = m_valid();
            check("occupancy<=3", 64'(mq.size() <= 3), 64'(1));
            check("instr_valid", 64'(bus.instr_valid_o), 64'(v));
            check("fetch_ready", 64'(bus.fetch_ready_o), 64'(mq.size() <= 1));
            if (v) begin
                c  = (mq[0].h[1:0] != 2'b11);
                ei = c ? {16'h0, mq[0].h} : {mq[1].h, mq[0].h};
                check("instr", 64'(bus.instr_o), 64'(ei));
                check("instr_addr", bus.instr_addr_o, mq[0].pc);
                check("is_compressed", 64'(bus.is_compressed_o), 64'(c));
`ifdef REALIGN_STRADDLE_FLAG_EN
                check("straddle", 64'(straddle), 64'(!c && (mq[0].wid != mq[1].wid)));
`endif
            end else if (mq.size() == 0) begin
                check("instr_idle", 64'(bus.instr_o), 64'(0));
                check("addr_idle", bus.instr_addr_o, 64'(0));
                check("comp_idle", 64'(bus.is_compressed_o), 64'(0));
            end
        end
    end

    task automatic lit(string nm, logic [31:0] ei, logic [63:0] ea, logic ec);
        check({nm, ".valid"}, 64'(bus.instr_valid_o), 64'(1));
        check({nm, ".instr"}, 64'(bus.instr_o), 64'(ei));
        check({nm, ".addr"}, bus.instr_addr_o, ea);
        check({nm, ".comp"}, 64'(bus.is_compressed_o), 64'(ec));
    endtask

    task automatic drive(logic fv, logic [63:0] a, logic [31:0] d, logic rdy);
        bus.fetch_valid_i = fv;
        bus.fetch_addr_i  = a;
        bus.fetch_data_i  = d;
        bus.instr_ready_i = rdy;
    endtask

    function automatic logic [15:0] rh();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    logic [63:0] nxt;
    logic [63:0] a;
    bit          pend;
    bit          fv;
    bit          fl;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1;
        check("reset.valid", 64'(bus.instr_valid_o), 64'(0));
        check("reset.ready", 64'(bus.fetch_ready_o), 64'(1));
        check("reset.instr", 64'(bus.instr_o), 64'(0));
        check("reset.addr", bus.instr_addr_o, 64'(0));
        check("reset.comp", 64'(bus.is_compressed_o), 64'(0));
`ifdef REALIGN_STRADDLE_FLAG_EN
        check("reset.straddle", 64'(straddle), 64'(0));
`endif

        // Two RVC in one word
        drive(1'b1, 64'h1000, 32'h0001_4501, 1'b1);
        @(negedge clk); lit("rvc0", 32'h0000_4501, 64'h1000, 1'b1);
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        @(negedge clk); lit("rvc1", 32'h0000_0001, 64'h1002, 1'b1);
        @(negedge clk);

        // RVC then a 32-bit instruction straddling into the next word
        drive(1'b1, 64'h1000, 32'h0513_0001, 1'b1);
        @(negedge clk); lit("st.rvc", 32'h0000_0001, 64'h1000, 1'b1);
        drive(1'b1, 64'h1004, 32'h1234_00A0, 1'b1);
        @(negedge clk);
        check("st.half.valid", 64'(bus.instr_valid_o), 64'(0));
        check("st.half.ready", 64'(bus.fetch_ready_o), 64'(1));
        @(negedge clk); lit("st.full", 32'h00A0_0513, 64'h1002, 1'b0);
`ifdef REALIGN_STRADDLE_FLAG_EN
        check("st.straddle", 64'(straddle), 64'(1));
`endif
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        @(negedge clk); lit("st.tail", 32'h0000_1234, 64'h1006, 1'b1);
        @(negedge clk);

        // Redirect into the upper halfword
        drive(1'b1, 64'h2002, 32'h0000_FFFF, 1'b1);
        @(negedge clk); lit("redir", 32'h0000_0000, 64'h2002, 1'b1);
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        @(negedge clk);

        // Backpressure with three halfwords held
        drive(1'b1, 64'h3002, 32'h0513_FFFF, 1'b0);
        @(negedge clk);
        drive(1'b1, 64'h3004, 32'h4501_00A0, 1'b0);
        @(negedge clk);
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            lit("stall", 32'h00A0_0513, 64'h3002, 1'b0);
            check("stall.ready", 64'(bus.fetch_ready_o), 64'(0));
            @(negedge clk);
        end
        lit("stall.end", 32'h00A0_0513, 64'h3002, 1'b0);
        bus.instr_ready_i = 1'b1;
        @(negedge clk); lit("drain", 32'h0000_4501, 64'h3006, 1'b1);
        @(negedge clk);
        check("drain.empty", 64'(bus.instr_valid_o), 64'(0));

        // Flush with push and pop both firing
        drive(1'b1, 64'h4002, 32'h4501_0000, 1'b0);
        @(negedge clk); lit("pre_flush", 32'h0000_4501, 64'h4002, 1'b1);
        drive(1'b1, 64'h4004, 32'h0001_0001, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        check("flush.valid", 64'(bus.instr_valid_o), 64'(0));
        check("flush.ready", 64'(bus.fetch_ready_o), 64'(1));

        // Reset while a straddling low half is held
        drive(1'b1, 64'h5002, 32'h0513_0000, 1'b1);
        @(negedge clk);
        check("mid.valid", 64'(bus.instr_valid_o), 64'(0));
        rst = 1'b1;
        drive(1'b1, 64'h5004, 32'h0000_00A0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 64'h6000, 32'h0001_4501, 1'b1);
        check("rst.valid", 64'(bus.instr_valid_o), 64'(0));
        check("rst.ready", 64'(bus.fetch_ready_o), 64'(1));
        @(negedge clk); lit("post_rst", 32'h0000_4501, 64'h6000, 1'b1);
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        @(negedge clk); lit("post_rst1", 32'h0000_0001, 64'h6002, 1'b1);
        @(negedge clk);

        // Random stream: contiguous words, stalls, flushes followed by redirects
        pend = 1;
        nxt  = 64'h0;
        for (int n = 0; n < 1500; n++) begin
            fl = ($urandom_range(0, 24) == 0);
            fv = ($urandom_range(0, 3) != 0);
            a  = pend ? {32'h0, $urandom} : nxt;
            flush = fl;
            drive(fv, a, {rh(), rh()}, ($urandom_range(0, 3) != 0));
            if (fl) pend = 1;
            else if (fv && (mq.size() <= 1)) begin
                pend = 0;
                nxt  = {a[63:2], 2'b00} + 64'd4;
            end
            @(negedge clk);
        end
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        repeat (4) @(negedge clk);
        check("final.empty", 64'(bus.instr_valid_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
